// File: rtl/gc_controller_poll_if.sv
// Fabric-side bundle for the GameCube controller poller.
// Fabric drives enable/rumble; the poller returns button state and status pulses.
interface gc_controller_poll_if;
   logic        enable;
   logic        rumble;
   logic [63:0] buttons;
   logic        data_valid;
   logic        timeout_err;
   logic        busy;

   modport master (
      output enable, rumble,
      input  buttons, data_valid, timeout_err, busy
   );

   modport slave (
      input  enable, rumble,
      output buttons, data_valid, timeout_err, busy
   );
endinterface

// File: rtl/gc_controller_poll.sv
// GameCube controller poller: sends the 0x400300 poll, captures the 64-bit reply.
// Define GC_RUMBLE_EN to drive command bit 0 from the rumble input.
module gc_controller_poll #(
   parameter int CLK_PER_US     = 10,
   parameter int POLL_PERIOD_US = 16000,
   parameter int RX_TIMEOUT_US  = 100
) (
   input  logic                 SYSCLK,
   input  logic                 SYSRESET,
   gc_controller_poll_if.slave  bus,
   inout  wire                  controller_data
);

   localparam int CELL   = 4 * CLK_PER_US;
   localparam int SHORT  = CLK_PER_US;
   localparam int LONG   = 3 * CLK_PER_US;
   localparam int HALF   = 2 * CLK_PER_US;
   localparam int PERIOD = POLL_PERIOD_US * CLK_PER_US;
   localparam int TMO    = RX_TIMEOUT_US * CLK_PER_US;
   localparam int CW     = $clog2(CELL);
   localparam int PW     = $clog2(PERIOD);
   localparam int TW     = $clog2(TMO);
   localparam int SW     = $clog2(HALF);

   typedef enum logic [2:0] {
      IDLE,
      TX,
      RX_WAIT,
      RX_SAMPLE,
      DONE
   } state_t;

   state_t      state;
   state_t      nxt;
   logic [1:0]  sync;
   logic        prev;
   logic        line;
   logic        fall;
   logic [PW-1:0] pcnt;
   logic [CW-1:0] ccnt;
   logic [TW-1:0] tcnt;
   logic [SW-1:0] scnt;
   logic [4:0]  bidx;
   logic [5:0]  rcnt;
   logic [24:0] cmd_q;
   logic [23:0] cmd;
   logic [63:0] shreg;
   logic [63:0] buttons_q;
   logic        valid_q;
   logic        tmo_q;
   logic        pcnt_end;
   logic        cell_end;
   logic        tmo_end;
   logic        samp_end;
   logic        drive_low;

`ifdef GC_RUMBLE_EN
   assign cmd = 24'h400300 | {23'd0, bus.rumble};
`else
   logic unused_rumble;
   assign unused_rumble = bus.rumble;
   assign cmd = 24'h400300;
`endif

   assign line     = sync[1];
   assign fall     = prev & ~line;
   assign pcnt_end = (pcnt == PW'(PERIOD - 1));
   assign cell_end = (ccnt == CW'(CELL - 1));
   assign tmo_end  = (tcnt == TW'(TMO - 1));
   assign samp_end = (scnt == SW'(HALF - 1));

   // Current TX bit sits in cmd_q[24]; a '1' is the short low pulse.
   assign drive_low = (state == TX) &&
                      (ccnt < (cmd_q[24] ? CW'(SHORT) : CW'(LONG)));
   assign controller_data = drive_low ? 1'b0 : 1'bz;

   assign bus.buttons     = buttons_q;
   assign bus.data_valid  = valid_q;
   assign bus.timeout_err = tmo_q;
   assign bus.busy        = (state != IDLE);

   always_ff @(posedge SYSCLK or posedge SYSRESET) begin
      if (SYSRESET) begin
         state <= IDLE;
      end else begin
         state <= nxt;
      end
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE: begin
            if (pcnt_end && bus.enable) nxt = TX;
         end
         TX: begin
            if (cell_end && bidx == 5'd24) nxt = RX_WAIT;
         end
         RX_WAIT: begin
            if (fall)         nxt = RX_SAMPLE;
            else if (tmo_end) nxt = IDLE;
         end
         RX_SAMPLE: begin
            if (samp_end) nxt = (rcnt == 6'd63) ? DONE : RX_WAIT;
         end
         DONE: begin
            nxt = IDLE;
         end
         default: begin
            nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge SYSCLK or posedge SYSRESET) begin
      if (SYSRESET) begin
         sync <= 2'b11;
         prev <= 1'b1;
      end else begin
         sync <= {sync[0], controller_data !== 1'b0};
         prev <= sync[1];
      end
   end

   always_ff @(posedge SYSCLK or posedge SYSRESET) begin
      if (SYSRESET) begin
         pcnt      <= '0;
         ccnt      <= '0;
         tcnt      <= '0;
         scnt      <= '0;
         bidx      <= '0;
         rcnt      <= '0;
         cmd_q     <= '0;
         shreg     <= '0;
         buttons_q <= '0;
         valid_q   <= 1'b0;
         tmo_q     <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         tmo_q   <= 1'b0;
         unique case (state)
            IDLE: begin
               // Hold at terminal count while disabled.
               if (!pcnt_end) begin
                  pcnt <= pcnt + 1'b1;
               end else if (bus.enable) begin
                  pcnt  <= '0;
                  ccnt  <= '0;
                  bidx  <= '0;
                  cmd_q <= {cmd, 1'b1};
               end
            end
            TX: begin
               if (cell_end) begin
                  ccnt  <= '0;
                  bidx  <= bidx + 1'b1;
                  cmd_q <= {cmd_q[23:0], 1'b0};
                  tcnt  <= '0;
                  rcnt  <= '0;
               end else begin
                  ccnt <= ccnt + 1'b1;
               end
            end
            RX_WAIT: begin
               if (fall) begin
                  scnt <= '0;
                  tcnt <= '0;
               end else if (tmo_end) begin
                  tmo_q <= 1'b1;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            RX_SAMPLE: begin
               if (samp_end) begin
                  shreg <= {shreg[62:0], line};
                  tcnt  <= '0;
                  if (rcnt != 6'd63) rcnt <= rcnt + 1'b1;
               end else begin
                  scnt <= scnt + 1'b1;
               end
            end
            DONE: begin
               buttons_q <= shreg;
               valid_q   <= 1'b1;
               pcnt      <= '0;
            end
            default: begin
               pcnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gc_controller_poll.sv
// Bench for gc_controller_poll: vector table, random polls and a controller model.
// Expected command follows GC_RUMBLE_EN when the bench is built with it.
module tb_gc_controller_poll;

   localparam int CPU    = 10;
   localparam int PUS    = 50;
   localparam int TUS    = 100;
   localparam int PERIOD = PUS * CPU;
   localparam int TMO    = TUS * CPU;
   localparam int CELL   = 4 * CPU;
`ifdef GC_RUMBLE_EN
   localparam bit RUMBLE_ON = 1'b1;
`else
   localparam bit RUMBLE_ON = 1'b0;
`endif

   typedef struct {
      logic        rum;
      int          n;
      logic [63:0] d;
      bit          ev;
      bit          et;
      logic [63:0] eb;
      bit          drop;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic drv = 1'b0;
   wire  controller_data;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   next_lo = 0;
   int   next_hi = 0;
   int   dv_cnt = 0;
   int   te_cnt = 0;
   int   dv_cyc = 0;
   int   te_cyc = 0;
   logic [63:0] dv_btn = '0;
   logic [63:0] model_btn = '0;
   vec_t tbl [5];

   gc_controller_poll_if bus ();

   pullup (controller_data);
   assign controller_data = drv ? 1'b0 : 1'bz;

   gc_controller_poll #(
      .CLK_PER_US     (CPU),
      .POLL_PERIOD_US (PUS),
      .RX_TIMEOUT_US  (TUS)
   ) dut (
      .SYSCLK          (clk),
      .SYSRESET        (rst),
      .bus             (bus),
      .controller_data (controller_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.data_valid === 1'b1) begin
         dv_cnt <= dv_cnt + 1;
         dv_cyc <= cyc;
         dv_btn <= bus.buttons;
      end
      if (bus.timeout_err === 1'b1) begin
         te_cnt <= te_cnt + 1;
         te_cyc <= cyc;
      end
   end

   initial begin
      #950000;
      $display("FAIL watchdog: cycle %0d reached, limit 95000", cyc);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic finish_now();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   endtask

   function automatic logic [24:0] exp_frame(input logic rum);
      return {24'h400300 | {23'd0, rum & RUMBLE_ON}, 1'b1};
   endfunction

   task automatic wait_fall(input int limit, output bit found);
      found = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (controller_data === 1'b0) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   // Called on the first low sample; samples 25 cells of 40 cycles.
   task automatic check_tx(input logic [24:0] expf);
      logic [24:0] got;
      bit          shape_ok;
      got = '0;
      shape_ok = 1'b1;
      for (int k = 0; k < 25; k++) begin
         int lows;
         bit seen_hi;
         lows = 0;
         seen_hi = 1'b0;
         for (int j = 0; j < CELL; j++) begin
            if (k != 0 || j != 0) @(negedge clk);
            if (k == 12 && j == 0) chk("busy_tx", bus.busy, 1);
            if (controller_data === 1'b0) begin
               if (seen_hi) shape_ok = 1'b0;
               lows++;
            end else begin
               seen_hi = 1'b1;
            end
         end
         if (lows == CPU)          got[24-k] = 1'b1;
         else if (lows == 3 * CPU) got[24-k] = 1'b0;
         else                      shape_ok = 1'b0;
      end
      chk("tx_frame", {shape_ok, got}, {1'b1, expf});
   endtask

   task automatic reply(input int n, input logic [63:0] d, output int lf);
      lf = cyc;
      for (int i = 0; i < n; i++) begin
         int lo;
         lo = d[63-i] ? CPU : 3 * CPU;
         drv = 1'b1;
         lf = cyc;
         repeat (lo) @(negedge clk);
         drv = 1'b0;
         repeat (CELL - lo) @(negedge clk);
      end
   endtask

   task automatic run_txn(input logic rum, input int n, input logic [63:0] d,
                          input bit ev, input bit et, input logic [63:0] eb,
                          input bit drop, input int rst_at);
      bit found;
      int s;
      int lf;
      int dv0;
      int te0;
      bus.rumble = rum;
      dv0 = dv_cnt;
      te0 = te_cnt;
      wait_fall(next_hi - cyc + 5, found);
      chk("poll_seen", found, 1);
      if (!found) finish_now();
      s = cyc;
      if (next_lo == next_hi) chk("poll_start", s, next_lo);
      else chk("poll_window", (s >= next_lo && s <= next_hi), 1);
      if (drop) bus.enable = 1'b0;
      check_tx(exp_frame(rum));
      repeat (20) @(negedge clk);
      if (rst_at >= 0) begin
         reply(rst_at, d, lf);
         rst = 1'b1;
         drv = 1'b0;
         #1;
         chk("rst_line", controller_data, 1);
         chk("rst_buttons", bus.buttons, 0);
         chk("rst_busy", bus.busy, 0);
         repeat (CPU) @(negedge clk);
         rst = 1'b0;
         next_lo = cyc + PERIOD;
         next_hi = next_lo;
         return;
      end
      reply(n, d, lf);
      if (n == 64) reply(1, 64'hFFFF_FFFF_FFFF_FFFF, s);
      for (int i = 0; i < TMO + 200; i++) begin
         if (dv_cnt != dv0 || te_cnt != te0) break;
         @(negedge clk);
      end
      repeat (5) @(negedge clk);
      chk("valid_cnt", dv_cnt - dv0, ev);
      chk("tmo_cnt", te_cnt - te0, et);
      chk("buttons", bus.buttons, eb);
      if (ev && dv_cnt != dv0) begin
         chk("valid_btn", dv_btn, eb);
         chk("valid_lat", (dv_cyc - lf >= 20 && dv_cyc - lf <= 28), 1);
      end
      if (et && te_cnt != te0) begin
         if (n == 0) chk("tmo_time", te_cyc, s + 25 * CELL + TMO);
         else chk("tmo_lat", (te_cyc - lf >= TMO + 18 &&
                              te_cyc - lf <= TMO + 28), 1);
      end
      if (dv_cnt != dv0)      next_lo = dv_cyc + PERIOD;
      else if (te_cnt != te0) next_lo = te_cyc + PERIOD;
      next_hi = next_lo;
   endtask

   initial begin
      bit          found;
      logic        rum;
      int          n;
      logic [63:0] d;
      logic [63:0] eb;

      tbl[0] = '{1'b0, 64, 64'h0080_8080_8080_1F1F, 1'b1, 1'b0,
                 64'h0080_8080_8080_1F1F, 1'b0};
      tbl[1] = '{1'b1, 0, 64'h0, 1'b0, 1'b1,
                 64'h0080_8080_8080_1F1F, 1'b0};
      tbl[2] = '{1'b0, 20, 64'hFFFF_0000_FFFF_0000, 1'b0, 1'b1,
                 64'h0080_8080_8080_1F1F, 1'b0};
      tbl[3] = '{1'b1, 64, 64'hA5A5_0F0F_1234_8001, 1'b1, 1'b0,
                 64'hA5A5_0F0F_1234_8001, 1'b1};
      tbl[4] = '{1'b0, 64, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
                 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};

      bus.enable = 1'b1;
      bus.rumble = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_line", controller_data, 1);
      chk("reset_busy", bus.busy, 0);
      chk("reset_buttons", bus.buttons, 0);
      chk("reset_valid", bus.data_valid, 0);
      chk("reset_tmo", bus.timeout_err, 0);
      repeat (CPU - 3) @(negedge clk);
      rst = 1'b0;
      next_lo = cyc + PERIOD;
      next_hi = next_lo;

      for (int i = 0; i < 5; i++) begin
         run_txn(tbl[i].rum, tbl[i].n, tbl[i].d, tbl[i].ev, tbl[i].et,
                 tbl[i].eb, tbl[i].drop, -1);
         model_btn = tbl[i].eb;
         if (tbl[i].drop) begin
            wait_fall(2 * PERIOD, found);
            chk("disabled_no_poll", found, 0);
            chk("disabled_busy", bus.busy, 0);
            bus.enable = 1'b1;
            next_lo = cyc + 1;
            next_hi = cyc + 1 + PERIOD;
         end
      end

      for (int i = 0; i < 4; i++) begin
         rum = 1'($urandom_range(0, 1));
         n = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 63) : 64;
         d = {$urandom, $urandom};
         eb = (n == 64) ? d : model_btn;
         run_txn(rum, n, d, n == 64, n != 64, eb, 1'b0, -1);
         model_btn = eb;
      end

      run_txn(1'b0, 10, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, 64'h0,
              1'b0, 10);
      model_btn = '0;
      d = {$urandom, $urandom};
      run_txn(1'b1, 64, d, 1'b1, 1'b0, d, 1'b0, -1);

      finish_now();
   end

endmodule
